// File: rtl/mem_access_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_access_bridge_if
//   Bundles the core-side access port and the memory-side req/ack port of
//   mem_access_bridge into one interface.
//   Core side : core_req, core_we, core_addr, core_wdata, core_funct3 (to bridge)
//               core_done, core_err, core_rdata                        (from bridge)
//   Mem side  : mem_req, mem_we, mem_addr, mem_wdata, mem_be           (from bridge)
//               mem_ack, mem_rdata                                     (to bridge)
//   Modports:
//     slave  - the bridge's view (it serves the core and drives the memory)
//     master - the environment's view (core + wait-state memory)
// ---------------------------------------------------------------------------
interface mem_access_bridge_if;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic        core_done;
    logic        core_err;
    logic [31:0] core_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_funct3,
        output core_done, core_err, core_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_funct3,
        input  core_done, core_err, core_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_bridge.sv
// ---------------------------------------------------------------------------
// mem_access_bridge
//   Converts a single-cycle core memory access into a req/ack handshake
//   towards a wait-state memory. Stores are lane-formatted (SB/SH/SW by
//   funct3) with byte enables; misaligned stores are rejected without a
//   memory access; requests that see no ack for TIMEOUT cycles are aborted.
//   Loads return the raw word; byte/halfword extraction happens downstream.
//
//   Parameters:
//     TIMEOUT  cycles spent in REQ without mem_ack before aborting (1..255)
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    mem_access_bridge_if.slave (core-side and memory-side signals)
//
//   All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module mem_access_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_bridge_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last counter value spent in REQ; the counter starts at 0 on entry, so
    // mem_req is high for exactly TIMEOUT cycles when no ack arrives.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    // Byte enables for a store of width funct3 at byte offset off.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << off;
            3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;  // SW and reserved encodings
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data onto every lane it may occupy.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{wd[7:0]}};
            3'b001:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Store alignment check; SB can never be misaligned.
    function automatic logic store_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            3'b000:  mis = 1'b0;
            3'b001:  mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    state_t      state_q,      state_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic        mem_req_q,    mem_req_d;
    logic        mem_we_q,     mem_we_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic [3:0]  mem_be_q,     mem_be_d;
    logic        core_done_q,  core_done_d;
    logic        core_err_q,   core_err_d;
    logic [31:0] core_rdata_q, core_rdata_d;

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        core_done_d  = 1'b0;
        core_err_d   = 1'b0;
        core_rdata_d = core_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.core_req) begin
                    if (bus.core_we && store_misaligned(bus.core_funct3, bus.core_addr[1:0])) begin
                        // Rejected store: report straight away, memory untouched.
                        state_d     = ST_DONE;
                        core_done_d = 1'b1;
                        core_err_d  = 1'b1;
                    end else begin
                        state_d    = ST_REQ;
                        cnt_d      = 8'd0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = bus.core_we;
                        mem_addr_d = {bus.core_addr[31:2], 2'b00};
                        if (bus.core_we) begin
                            mem_be_d    = store_be(bus.core_funct3, bus.core_addr[1:0]);
                            mem_wdata_d = store_data(bus.core_funct3, bus.core_wdata);
                        end else begin
                            // Loads always fetch the whole word.
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = bus.core_wdata;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (bus.mem_ack) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    core_done_d = 1'b1;
                    core_err_d  = 1'b0;
                    if (!mem_we_q) begin
                        core_rdata_d = bus.mem_rdata;
                    end else begin
                        core_rdata_d = core_rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    core_done_d = 1'b1;
                    core_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                // core_done/core_err are visible during this state only.
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_be_q     <= 4'd0;
            core_done_q  <= 1'b0;
            core_err_q   <= 1'b0;
            core_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            core_done_q  <= core_done_d;
            core_err_q   <= core_err_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.core_done  = core_done_q;
    assign bus.core_err   = core_err_q;
    assign bus.core_rdata = core_rdata_q;

endmodule

// File: tb/tb_mem_access_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_access_bridge
//   Self-checking bench for mem_access_bridge. A transaction-level model sets
//   the expected outputs for every cycle; one compare process checks the DUT
//   against them on each falling edge. Directed accesses pin the model with
//   literal values, then randomized accesses run with noise on ignored inputs.
// ---------------------------------------------------------------------------
module tb_mem_access_bridge;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_bridge_if bus();

    mem_access_bridge #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected DUT outputs for the current cycle
    bit          chk_en = 1'b0;
    logic        exp_done, exp_err, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare process: DUT outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("core_done",  {31'd0, bus.core_done}, {31'd0, exp_done});
            check("core_err",   {31'd0, bus.core_err},  {31'd0, exp_err});
            check("core_rdata", bus.core_rdata, exp_rdata);
            check("mem_req",    {31'd0, bus.mem_req},   {31'd0, exp_req});
            check("mem_we",     {31'd0, bus.mem_we},    {31'd0, exp_we});
            if (exp_req) begin
                check("mem_addr", bus.mem_addr, exp_addr);
                check("mem_be",   {28'd0, bus.mem_be}, {28'd0, exp_be});
                if (exp_we) begin
                    check("mem_wdata", bus.mem_wdata, exp_wdata);
                end
            end
        end
    end

    // ---------------- model ----------------
    function automatic logic [3:0] model_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        if (!we)        return 4'hF;
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return 4'(3 << ((off / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (f3 == 3'd0) return (w & 32'h000000FF) * 32'h01010101;
        if (f3 == 3'd1) return (w & 32'h0000FFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic bit model_misaligned(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        if (!we) return 1'b0;
        if (f3 == 3'd0) return 1'b0;
        if (f3 == 3'd1) return (off % 2) != 0;
        return off != 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle_exp();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_req  = 1'b0;
        exp_we   = 1'b0;
    endtask

    task automatic scramble_core(input bit noise);
        bus.core_req = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        if (noise) begin
            bus.core_we     = 1'($urandom_range(1, 0));
            bus.core_addr   = $urandom;
            bus.core_wdata  = $urandom;
            bus.core_funct3 = 3'($urandom_range(7, 0));
        end
    endtask

    // One core access. delay = REQ cycle index of the ack (>= TO: never acked).
    // lat = cycles from request to observed core_done (-1 if never seen).
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int delay, input logic [31:0] rd,
                          input bit noise, output int lat, output logic [3:0] s_be,
                          output logic [31:0] s_addr, output logic [31:0] s_wdata);
        int  c0;
        bit  acked;
        c0     = cyc;
        lat    = -1;
        acked  = 1'b0;
        s_be   = 4'd0;
        s_addr = 32'd0;
        s_wdata = 32'd0;
        // cycle 0: request (DUT idle)
        set_idle_exp();
        bus.core_req    = 1'b1;
        bus.core_we     = we;
        bus.core_addr   = addr;
        bus.core_wdata  = wdata;
        bus.core_funct3 = f3;
        bus.mem_ack     = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        bus.mem_rdata   = $urandom;
        step();
        if (model_misaligned(we, f3, addr)) begin
            exp_done = 1'b1;
            exp_err  = 1'b1;
            scramble_core(noise);
            bus.mem_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            if (bus.core_done) lat = cyc - c0;
        end else begin
            for (int i = 0; i < TO; i++) begin
                exp_req   = 1'b1;
                exp_we    = we;
                exp_addr  = addr & 32'hFFFFFFFC;
                exp_be    = model_be(we, f3, addr);
                exp_wdata = model_wdata(f3, wdata);
                if (i == 0) begin
                    s_be    = bus.mem_be;
                    s_addr  = bus.mem_addr;
                    s_wdata = bus.mem_wdata;
                end
                acked         = (i == delay);
                bus.mem_ack   = acked;
                bus.mem_rdata = acked ? rd : $urandom;
                scramble_core(noise);
                if (acked || i == TO - 1) break;
                step();
            end
            step();
            set_idle_exp();
            exp_done = 1'b1;
            exp_err  = !acked;
            if (acked && !we) exp_rdata = rd;
            scramble_core(noise);
            bus.mem_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            if (bus.core_done) lat = cyc - c0;
        end
        step();
        set_idle_exp();
        bus.core_req = 1'b0;
        bus.mem_ack  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    endtask

    // Load that never gets acked, with reset asserted in REQ cycle k.
    task automatic reset_mid(input int k);
        set_idle_exp();
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 32'h0000_0080;
        bus.mem_ack   = 1'b0;
        step();
        for (int i = 0; i <= k; i++) begin
            exp_req  = 1'b1;
            exp_we   = 1'b0;
            exp_addr = 32'h0000_0080;
            exp_be   = 4'hF;
            scramble_core(1'b1);
            if (i == k) begin
                reset = 1'b1;
            end else begin
                step();
            end
        end
        step();
        reset     = 1'b0;
        set_idle_exp();
        exp_rdata = 32'd0;
        bus.core_req = 1'b0;
        step();
        step();
    endtask

    int          lat;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;

    initial begin
        reset           = 1'b1;
        bus.core_req    = 1'b0;
        bus.core_we     = 1'b0;
        bus.core_addr   = 32'd0;
        bus.core_wdata  = 32'd0;
        bus.core_funct3 = 3'd0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 32'd0;
        set_idle_exp();
        exp_rdata = 32'd0;
        exp_addr  = 32'd0;
        exp_be    = 4'd0;
        exp_wdata = 32'd0;
        step();
        chk_en = 1'b1;
        step();
        check("rst_mem_addr",  bus.mem_addr,  32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_be",    {28'd0, bus.mem_be}, 32'd0);
        reset = 1'b0;
        step();

        // Load 0x40, ack in third REQ cycle
        access(1'b0, 32'h40, 32'd0, 3'd0, 2, 32'hDEADBEEF, 1'b0, lat, s_be, s_addr, s_wdata);
        check("ld_lat",   32'(lat), 32'd4);
        check("ld_be",    {28'd0, s_be}, 32'h0000000F);
        check("ld_addr",  s_addr, 32'h40);
        check("ld_rdata", bus.core_rdata, 32'hDEADBEEF);

        // SB 0x103, immediate ack
        access(1'b1, 32'h103, 32'hA5, 3'b000, 0, 32'd0, 1'b0, lat, s_be, s_addr, s_wdata);
        check("sb_lat",   32'(lat), 32'd2);
        check("sb_addr",  s_addr, 32'h100);
        check("sb_be",    {28'd0, s_be}, 32'h00000008);
        check("sb_wdata", s_wdata, 32'hA5A5A5A5);

        // SH 0x22
        access(1'b1, 32'h22, 32'h1234, 3'b001, 1, 32'd0, 1'b1, lat, s_be, s_addr, s_wdata);
        check("sh_be",    {28'd0, s_be}, 32'h0000000C);
        check("sh_wdata", s_wdata, 32'h12341234);

        // Misaligned SW
        access(1'b1, 32'h21, 32'h55, 3'b010, 0, 32'd0, 1'b0, lat, s_be, s_addr, s_wdata);
        check("sw_mis_lat", 32'(lat), 32'd1);

        // Timeout, no ack
        access(1'b0, 32'h44, 32'd0, 3'd0, TO, 32'h11112222, 1'b1, lat, s_be, s_addr, s_wdata);
        check("to_lat",   32'(lat), 32'(TO + 1));
        check("to_rdata", bus.core_rdata, 32'hDEADBEEF);

        // Ack in the cycle the timeout would fire: ack wins
        access(1'b0, 32'h48, 32'd0, 3'd0, TO - 1, 32'hCAFEF00D, 1'b1, lat, s_be, s_addr, s_wdata);
        check("edge_lat",   32'(lat), 32'(TO + 1));
        check("edge_rdata", bus.core_rdata, 32'hCAFEF00D);

        // Reset mid-REQ, then a fresh request must be accepted
        reset_mid(3);
        access(1'b0, 32'h10, 32'd0, 3'd0, 0, 32'h0BADC0DE, 1'b0, lat, s_be, s_addr, s_wdata);
        check("post_rst_lat", 32'(lat), 32'd2);

        // Randomized accesses
        for (int n = 0; n < 250; n++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(7, 0));
            if ($urandom_range(3, 0) == 0) f3 = 3'd0;
            access(1'($urandom_range(1, 0)), $urandom, $urandom, f3,
                   int'($urandom_range(TO, 0)), $urandom, 1'($urandom_range(1, 0)),
                   lat, s_be, s_addr, s_wdata);
            if (n == 120) reset_mid(int'($urandom_range(TO - 2, 0)));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
